// File: rtl/latch_bank_arbiter_if.sv
// Request/grant and latch-bank bus between requesters, the write scheduler and the D-latch bank.
interface latch_bank_arbiter_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4
);
   logic [NREQ-1:0]       REQ;
   logic [NREQ*WIDTH-1:0] DIN;
   logic [WIDTH-1:0]      Q_IN;
   logic [NREQ-1:0]       GNT;
   logic [NREQ-1:0]       DONE;
   logic                  LE;
   logic [WIDTH-1:0]      LD;
   logic                  BUSY;
   logic                  ERR;

   // Requesters and the latch bank readback.
   modport master (
      output REQ, DIN, Q_IN,
      input  GNT, DONE, LE, LD, BUSY, ERR
   );

   // The scheduler.
   modport slave (
      input  REQ, DIN, Q_IN,
      output GNT, DONE, LE, LD, BUSY, ERR
   );
endinterface

// File: rtl/latch_bank_arbiter.sv
// Round-robin write scheduler for a D-latch storage bank: grant, setup, enable window,
// hold/close with readback check and per-requester completion pulse.
module latch_bank_arbiter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned HOLD_CYC = 2
) (
   input logic                CLK,
   input logic                RST,
   latch_bank_arbiter_if.slave bus
);
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = 4;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ENABLE = 2'd2;
   localparam logic [1:0] S_CLOSE  = 2'd3;

   if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_hold_chk
      $error("latch_bank_arbiter: HOLD_CYC must be in 1..15");
   end
   if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
      $error("latch_bank_arbiter: NREQ must be in 2..8");
   end

   logic [1:0]       state_q, state_nxt;
   logic [NREQ-1:0]  gnt_q, gnt_nxt;
   logic [NREQ-1:0]  done_q, done_nxt;
   logic             le_q, le_nxt;
   logic [WIDTH-1:0] ld_q, ld_nxt;
   logic             busy_q, busy_nxt;
   logic             err_q, err_nxt;
   logic [PW-1:0]    ptr_q, ptr_nxt;
   logic [PW-1:0]    win_q, win_nxt;
   logic [CW-1:0]    cnt_q, cnt_nxt;

   logic [PW-1:0]    pick_c;
   logic             found_c;
   logic [PW-1:0]    idx;

   // Wrap-around search upward from the round-robin pointer.
   always_comb begin
      pick_c  = ptr_q;
      found_c = 1'b0;
      idx     = ptr_q;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found_c && bus.REQ[idx]) begin
            found_c = 1'b1;
            pick_c  = idx;
         end
         idx = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nxt = state_q;
      gnt_nxt   = gnt_q;
      done_nxt  = done_q;
      le_nxt    = le_q;
      ld_nxt    = ld_q;
      busy_nxt  = busy_q;
      err_nxt   = err_q;
      ptr_nxt   = ptr_q;
      win_nxt   = win_q;
      cnt_nxt   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (found_c) begin
               win_nxt          = pick_c;
               ld_nxt           = bus.DIN[pick_c*WIDTH +: WIDTH];
               gnt_nxt          = '0;
               gnt_nxt[pick_c]  = 1'b1;
               busy_nxt         = 1'b1;
               state_nxt        = S_SETUP;
            end
         end
         S_SETUP: begin
            le_nxt    = 1'b1;
            cnt_nxt   = CW'(HOLD_CYC - 1);
            state_nxt = S_ENABLE;
         end
         S_ENABLE: begin
            if (cnt_q == '0) begin
               le_nxt    = 1'b0;
               done_nxt  = gnt_q;
               state_nxt = S_CLOSE;
            end else begin
               cnt_nxt = cnt_q - 1'b1;
            end
         end
         S_CLOSE: begin
            // LD stays driven through this cycle so the latches see hold time.
            if (bus.Q_IN != ld_q) err_nxt = 1'b1;
            gnt_nxt   = '0;
            done_nxt  = '0;
            busy_nxt  = 1'b0;
            ptr_nxt   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         le_q    <= 1'b0;
         ld_q    <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         ptr_q   <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         gnt_q   <= gnt_nxt;
         done_q  <= done_nxt;
         le_q    <= le_nxt;
         ld_q    <= ld_nxt;
         busy_q  <= busy_nxt;
         err_q   <= err_nxt;
         ptr_q   <= ptr_nxt;
         win_q   <= win_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   assign bus.GNT  = gnt_q;
   assign bus.DONE = done_q;
   assign bus.LE   = le_q;
   assign bus.LD   = ld_q;
   assign bus.BUSY = busy_q;
   assign bus.ERR  = err_q;
endmodule
